// File: rtl/vsub_stream.sv
// Streaming element-wise vector subtractor (diff = a - b) with length control and a 2-entry output FIFO.
// Optional build macro VSUB_SAT_EN: signed saturating subtract plus a per-element sat_flag output.
module vsub_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  out_last
`ifdef VSUB_SAT_EN
    ,
    output logic                  sat_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] diff;
        logic                  last;
`ifdef VSUB_SAT_EN
        logic                  sat;
`endif
    } entry_t;

    state_e               state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] cnt_d;
    logic                 done_q;

    entry_t               mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           occ_q;
    logic [1:0]           occ_d;

    logic                 push;
    logic                 pop;
    entry_t               push_entry;
    entry_t               head;

    // Input readiness looks only at registered state so it never combinationally depends on out_ready.
    assign in_ready  = (state_q == RUN) && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem_q[rd_ptr_q];
    assign diff      = head.diff;
    assign out_last  = head.last;
`ifdef VSUB_SAT_EN
    assign sat_flag  = head.sat;
`endif

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign cnt_d = cnt_q + LEN_WIDTH'(1);

`ifdef VSUB_SAT_EN
    logic [DATA_WIDTH:0] wide;
    assign wide = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
`endif

    // NOTE: every field gets a default first so the combinational block cannot infer a latch.
    always_comb begin
        push_entry      = '0;
        push_entry.last = (cnt_q == len_q - LEN_WIDTH'(1));
`ifdef VSUB_SAT_EN
        if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
            // Sign bit of the wide result tells which way the true difference overflowed.
            push_entry.sat  = 1'b1;
            push_entry.diff = wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            push_entry.diff = wide[DATA_WIDTH-1:0];
        end
`else
        push_entry.diff = a - b;
`endif
    end

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            len_q   <= len;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (push) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occ_q == 2'd0) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the buffer storage is reset because diff/out_last must read zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_d;
        end
    end

endmodule
